// File: rtl/note_sprite_drawer.sv
`default_nettype none
// ============================================================================
// Module      : note_sprite_drawer
// Description : Redraws an 8x8 note sprite at a fixed column on a VGA
//               framebuffer. Each accepted frame_tick first erases the
//               sprite at its previous row and then draws it at the newly
//               latched row, one pixel per cycle. Pixels whose row falls
//               at or below line 240 are suppressed (plot=0) while the
//               pixel sweep continues.
//               Optional build macro: DRAWER_SKIP_UNCHANGED_EN -- when
//               defined, a redraw request at an unchanged row skips the
//               erase/draw sweep and completes immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module note_sprite_drawer #(
    parameter logic [8:0] X_POS         = 9'd40,
    parameter logic [2:0] SPRITE_COLOUR = 3'b110,
    parameter logic [2:0] BG_COLOUR     = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic [7:0] oy,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] LAST_PIX  = 6'd63;
    localparam logic [8:0] ROW_LIMIT = 9'd240;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] prev_y_q, prev_y_d;
    logic [7:0] new_y_q, new_y_d;
    logic       has_prev_q, has_prev_d;

    logic [8:0] vga_x_q;
    logic [7:0] vga_y_q;
    logic [2:0] colour_q;
    logic       plot_q;
    logic       busy_q;
    logic       done_q;

    // Pixel that will be on the outputs during the next cycle
    logic       pix_active_d;
    logic [7:0] pix_base_d;
    logic [8:0] pix_row_d;
    logic [8:0] vga_x_d;
    logic [2:0] colour_d;
    logic       plot_d;

    // Next-state logic: request acceptance, pixel sweep and completion
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prev_y_d   = prev_y_q;
        new_y_d    = new_y_q;
        has_prev_d = has_prev_q;
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    new_y_d = oy;
                    cnt_d   = 6'd0;
`ifdef DRAWER_SKIP_UNCHANGED_EN
                    if (has_prev_q && (oy == prev_y_q)) begin
                        state_d = S_DONE;
                    end else if (has_prev_q) begin
                        state_d = S_ERASE;
                    end else begin
                        state_d = S_DRAW;
                    end
`else
                    state_d = has_prev_q ? S_ERASE : S_DRAW;
`endif
                end
            end
            S_ERASE: begin
                if (cnt_q == LAST_PIX) begin
                    cnt_d   = 6'd0;
                    state_d = S_DRAW;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DRAW: begin
                if (cnt_q == LAST_PIX) begin
                    cnt_d   = 6'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DONE: begin
                prev_y_d   = new_y_q;
                has_prev_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pixel address/colour for the upcoming cycle, so the registered
    // outputs line up with the state being entered rather than lagging it
    always_comb begin
        pix_active_d = (state_d == S_ERASE) || (state_d == S_DRAW);
        pix_base_d   = (state_d == S_ERASE) ? prev_y_q : new_y_d;
        pix_row_d    = {1'b0, pix_base_d} + {6'd0, cnt_d[5:3]};
        vga_x_d      = X_POS + {6'd0, cnt_d[2:0]};
        colour_d     = (state_d == S_ERASE) ? BG_COLOUR : SPRITE_COLOUR;
        plot_d       = pix_active_d && (pix_row_d < ROW_LIMIT);
    end

    // State, sweep counter, row history and registered VGA outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            prev_y_q   <= 8'd0;
            new_y_q    <= 8'd0;
            has_prev_q <= 1'b0;
            vga_x_q    <= 9'd0;
            vga_y_q    <= 8'd0;
            colour_q   <= 3'd0;
            plot_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_y_q   <= prev_y_d;
            new_y_q    <= new_y_d;
            has_prev_q <= has_prev_d;
            plot_q     <= plot_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
            // Address and colour hold their last value outside a sweep
            if (pix_active_d) begin
                vga_x_q  <= vga_x_d;
                vga_y_q  <= pix_row_d[7:0];
                colour_q <= colour_d;
            end
        end
    end

    assign vga_x  = vga_x_q;
    assign vga_y  = vga_y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_note_sprite_drawer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_note_sprite_drawer
// Description : Self-checking bench for note_sprite_drawer. A reference
//               model expands every accepted redraw into the list of
//               expected per-cycle outputs; a vector table checks plot
//               counts and completion latency of known frame sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_sprite_drawer;

    localparam logic [8:0] XP = 9'd40;
    localparam logic [2:0] SC = 3'b110;
    localparam logic [2:0] BC = 3'b000;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] oy = 8'd0;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    note_sprite_drawer #(
        .X_POS        (XP),
        .SPRITE_COLOUR(SC),
        .BG_COLOUR    (BC)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .frame_tick(frame_tick),
        .oy        (oy),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       plot;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } exp_t;

    typedef struct {
        logic [7:0] oy;
        int         plots;
        int         done_at;
    } vec_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   m_has_prev = 1'b0;
    int   m_prev_y   = 0;
    bit   m_busy     = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One sprite pixel: column = index mod 8, row = base + index div 8
    task automatic push_pixel(input int base, input int p, input logic [2:0] c);
        exp_t e;
        int   yy;
        yy     = base + p / 8;
        e      = '0;
        e.busy = 1'b1;
        e.plot = (yy < 240);
        e.x    = XP + 9'(p % 8);
        e.y    = 8'(yy);
        e.c    = c;
        q.push_back(e);
    endtask

    // Expected output list for one accepted redraw request
    task automatic model_accept(input int new_y);
        exp_t e;
        bit   skip;
        skip = 1'b0;
`ifdef DRAWER_SKIP_UNCHANGED_EN
        skip = m_has_prev && (new_y == m_prev_y);
`endif
        if (!skip) begin
            if (m_has_prev)
                for (int p = 0; p < 64; p++) push_pixel(m_prev_y, p, BC);
            for (int p = 0; p < 64; p++) push_pixel(new_y, p, SC);
        end
        e      = '0;
        e.busy = 1'b1;
        e.done = 1'b1;
        q.push_back(e);
        m_has_prev = 1'b1;
        m_prev_y   = new_y;
    endtask

    // Advance one clock, update the model with the inputs seen at the edge,
    // then compare the DUT outputs against the model
    task automatic step();
        exp_t       e;
        bit         tick_s;
        bit         rst_s;
        logic [7:0] oy_s;
        tick_s = frame_tick;
        rst_s  = resetn;
        oy_s   = oy;
        @(posedge clk);
        #1;
        e = '0;
        if (!rst_s) begin
            q.delete();
            m_has_prev = 1'b0;
            m_prev_y   = 0;
        end else begin
            if (q.size() == 0 && !m_busy && tick_s) model_accept(int'(oy_s));
            if (q.size() > 0) e = q.pop_front();
        end
        m_busy = e.busy;
        chk("busy", int'(busy), int'(e.busy));
        chk("done", int'(done), int'(e.done));
        chk("plot", int'(plot), int'(e.plot));
        if (e.plot) begin
            chk("vga_x", int'(vga_x), int'(e.x));
            chk("vga_y", int'(vga_y), int'(e.y));
            chk("colour", int'(colour), int'(e.c));
        end
        if (!rst_s) begin
            chk("rst_vga_x", int'(vga_x), 0);
            chk("rst_vga_y", int'(vga_y), 0);
            chk("rst_colour", int'(colour), 0);
        end
    endtask

    // Issue one request from idle and follow it to its done pulse
    task automatic run_frame(input logic [7:0] v, output int plots, output int done_at);
        frame_tick = 1'b1;
        oy         = v;
        plots      = 0;
        done_at    = -1;
        for (int c = 1; c <= 300; c++) begin
            step();
            frame_tick = 1'b0;
            if (plot) plots++;
            if (done) begin
                done_at = c;
                break;
            end
        end
        step();
    endtask

    vec_t tbl[8];
    int   p_got;
    int   d_got;

    initial begin
        tbl[0] = '{8'd50,  64, 65};
        tbl[1] = '{8'd60,  128, 129};
        tbl[2] = '{8'd236, 96, 129};
`ifdef DRAWER_SKIP_UNCHANGED_EN
        tbl[3] = '{8'd236, 0, 1};
`else
        tbl[3] = '{8'd236, 64, 129};
`endif
        tbl[4] = '{8'd60,  96, 129};
`ifdef DRAWER_SKIP_UNCHANGED_EN
        tbl[5] = '{8'd60,  0, 1};
`else
        tbl[5] = '{8'd60,  128, 129};
`endif
        tbl[6] = '{8'd255, 64, 129};
        tbl[7] = '{8'd0,   64, 129};

        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();

        foreach (tbl[i]) begin
            run_frame(tbl[i].oy, p_got, d_got);
            chk($sformatf("vec%0d_plots", i), p_got, tbl[i].plots);
            chk($sformatf("vec%0d_done_at", i), d_got, tbl[i].done_at);
        end

        // Request during DRAW with a different row must be ignored
        frame_tick = 1'b1;
        oy         = 8'd100;
        step();
        frame_tick = 1'b0;
        for (int c = 0; c < 69; c++) step();
        chk("mid_draw_busy", int'(busy), 1);
        frame_tick = 1'b1;
        oy         = 8'd200;
        step();
        frame_tick = 1'b0;
        oy         = 8'd0;
        for (int c = 0; c < 200 && m_busy; c++) step();
        chk("ignored_tick_idle", int'(busy), 0);
        run_frame(8'd100, p_got, d_got);
`ifdef DRAWER_SKIP_UNCHANGED_EN
        chk("prev_kept_plots", p_got, 0);
`else
        chk("prev_kept_plots", p_got, 128);
`endif

        // Reset in the middle of an erase sweep
        frame_tick = 1'b1;
        oy         = 8'd30;
        step();
        frame_tick = 1'b0;
        for (int c = 0; c < 19; c++) step();
        chk("pre_rst_erase_colour", int'(colour), int'(BC));
        resetn = 1'b0;
        step();
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        resetn = 1'b1;
        step();
        run_frame(8'd30, p_got, d_got);
        chk("post_rst_plots", p_got, 64);
        chk("post_rst_done_at", d_got, 65);

        // Randomized requests, stray ticks while busy and occasional resets
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) oy = 8'(m_prev_y);
            else oy = 8'($urandom_range(0, 255));
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            for (int c = 0; c < 200 && m_busy; c++) begin
                frame_tick = ($urandom_range(0, 9) == 0);
                oy         = 8'($urandom);
                if ($urandom_range(0, 199) == 0) resetn = 1'b0;
                step();
                resetn     = 1'b1;
                frame_tick = 1'b0;
            end
            if (m_busy) chk("random_frame_timeout", 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/note_sprite_drawer.md
NOTE_SPRITE_DRAWER -- requirements
Module: note_sprite_drawer

Interface
REQ-001 Parameter X_POS, default 9'd40, fixed sprite left column (SHALL be ≤ 312).
REQ-002 Parameter SPRITE_COLOUR, default 3'b110, sprite pixel colour.
REQ-003 Parameter BG_COLOUR, default 3'b000, erase colour.
REQ-004 clk  input  1  system clock; all state SHALL update on posedge clk.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 frame_tick  input  1  one-cycle pulse requesting a redraw at the current oy.
REQ-007 oy  input  8  sprite top row from the double-buffered y stage, 0..255.
REQ-008 vga_x  output  9  pixel column to VGA adapter.
REQ-009 vga_y  output  8  pixel row to VGA adapter.
REQ-010 colour  output  3  pixel colour.
REQ-011 plot  output  1  pixel write strobe, one pixel per cycle.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at redraw completion.

Function
REQ-014 FSM states SHALL be IDLE, ERASE, DRAW, DONE.
REQ-015 IDLE: on frame_tick=1, latch oy into new_y; go to ERASE if has_prev=1, else DRAW; clear 6-bit pixel counter.
REQ-016 frame_tick SHALL be ignored in every state other than IDLE; oy SHALL be sampled only on the accepting edge.
REQ-017 Pixel index cnt: column = cnt[2:0], row = cnt[5:3]; row-major order, 64 pixels per 8x8 sprite.
REQ-018 ERASE: each cycle output (X_POS+col, prev_y+row, BG_COLOUR); after cnt=63, clear cnt and go to DRAW.
REQ-019 DRAW: each cycle output (X_POS+col, new_y+row, SPRITE_COLOUR); after cnt=63 go to DONE.
REQ-020 DONE: done=1 for one cycle, prev_y<=new_y, has_prev<=1, go to IDLE.
REQ-021 vga_x, vga_y, colour, plot SHALL be registered; first pixel visible the cycle after the accepting edge.
REQ-022 Row sum SHALL be computed 9 bits wide; if ≥ 240, plot SHALL be 0 for that pixel while cnt still advances.
REQ-023 plot SHALL be 0 in IDLE and DONE.
REQ-024 Unclipped redraw with has_prev=1: plot high 128 consecutive cycles, done on the following cycle; with has_prev=0: 64 cycles then done.
REQ-025 busy SHALL be asserted from the cycle after acceptance through the DONE cycle inclusive.

Reset
REQ-026 resetn=0 at any posedge, including mid-ERASE/DRAW, SHALL force IDLE with cnt=0, prev_y=0, new_y=0, has_prev=0.
REQ-027 Reset values: vga_x=0, vga_y=0, colour=0, plot=0, busy=0, done=0.
REQ-028 First accepted frame_tick after reset SHALL skip ERASE.

Configuration
REQ-029 Macro DRAWER_SKIP_UNCHANGED_EN defined: in IDLE, if frame_tick=1, has_prev=1 and oy==prev_y, go directly to DONE (no plot cycles, done on next cycle).
REQ-030 Macro undefined: every accepted frame_tick SHALL perform the full ERASE/DRAW sequence regardless of oy.

Verification
REQ-031 Reset, frame_tick with oy=50 -> 64 plot cycles, x 40..47, y 50..57, colour 110, then done pulse; no erase.
REQ-032 Then frame_tick with oy=60 -> 64 erase pixels at y 50..57 colour 000, then 64 draw pixels at y 60..67, done after cycle 128.
REQ-033 oy=236 -> rows 236..239 plotted, rows 240..243 plot=0, cnt continues, done after 64 draw cycles.
REQ-034 frame_tick pulsed during DRAW with oy changed -> ignored; pixels and prev_y reflect originally latched value.
REQ-035 resetn=0 at erase pixel 20 -> next cycle plot=0, busy=0; next frame_tick skips ERASE.
REQ-036 Repeat oy=60 -> with DRAWER_SKIP_UNCHANGED_EN: zero plot cycles, done next cycle; without: 128 plot cycles.
